// File: rtl/stft_pkg.sv
// Shared definitions for the STFT/CNN datapath blocks.
//   clog2       : ceiling log2, for sizing address and count fields
//   rpc_state_t : read_pack_copy control states
package stft_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rpc_state_t;

endpackage

// File: rtl/read_pack_copy_lane_packer.sv
// lane_packer: gathers PACK captured words into one wide word, first word in
// the MSB lane, and emits a registered write strobe/data.
//   iCLK, iRST   : clock, synchronous active-high reset
//   iVALID       : a source word is being captured this cycle
//   iDATA        : captured source word
//   iFLUSH       : the captured word is the last of the job; write now
//   oWR_EN       : registered write strobe
//   oWR_DATA     : registered packed word (unfilled lanes zero)
//   oWR_LAST     : registered; the current write is the final one of the job
module lane_packer
  import stft_pkg::*;
#(
  parameter int unsigned DW   = 28,
  parameter int unsigned PACK = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iVALID,
  input  logic [DW-1:0]      iDATA,
  input  logic               iFLUSH,
  output logic               oWR_EN,
  output logic [DW*PACK-1:0] oWR_DATA,
  output logic               oWR_LAST
);

  localparam int unsigned LANE_W = (PACK > 1) ? clog2(PACK) : 1;

  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [DW*PACK-1:0] pack_q, pack_d;
  logic [DW*PACK-1:0] merged;
  logic               wr_en_q, wr_en_d;
  logic [DW*PACK-1:0] wr_data_q, wr_data_d;
  logic               wr_last_q, wr_last_d;

  always_comb begin
    merged    = pack_q;
    for (int unsigned l = 0; l < PACK; l++) begin
      if (lane_q == LANE_W'(l)) merged[(PACK-1-l)*DW +: DW] = iDATA;
    end
    lane_d    = lane_q;
    pack_d    = pack_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_last_d = 1'b0;
    if (iVALID) begin
      if ((lane_q == LANE_W'(PACK-1)) || iFLUSH) begin
        // The write path takes the merged word directly, so the pack
        // register can restart the next group in the same cycle.
        wr_en_d   = 1'b1;
        wr_data_d = merged;
        wr_last_d = iFLUSH;
        pack_d    = '0;
        lane_d    = '0;
      end else begin
        pack_d = merged;
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lane_q    <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_last_q <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_last_q <= wr_last_d;
    end
  end

  assign oWR_EN   = wr_en_q;
  assign oWR_DATA = wr_data_q;
  assign oWR_LAST = wr_last_q;

endmodule

// File: rtl/read_pack_copy.sv
// read_pack_copy: reads iLEN narrow words from a source RAM, packs PACK of
// them per wide word (first word in the MSB lane) and writes the wide words
// to consecutive destination addresses; a partial tail is zero-padded.
//   iCLK, iRST          : clock, synchronous active-high reset (aborts a job)
//   iSTART, iLEN        : job request (IDLE only) and length, clamped to SRC_DEPTH
//   oRD_EN/oRD_ADDR     : source read strobe/address
//   iRD_DATA            : source data, RD_LAT cycles after oRD_EN
//   oWR_EN/oWR_ADDR/oWR_DATA : destination write
//   oBUSY, oDONE        : job in progress, one-cycle completion pulse
module read_pack_copy
  import stft_pkg::*;
#(
  parameter int unsigned DW        = 28,
  parameter int unsigned PACK      = 4,
  parameter int unsigned SRC_DEPTH = 36,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned SRC_AW = (clog2(SRC_DEPTH) > 0) ? clog2(SRC_DEPTH) : 1,
  localparam int unsigned DST_AW = (clog2((SRC_DEPTH + PACK - 1) / PACK) > 0) ?
                                   clog2((SRC_DEPTH + PACK - 1) / PACK) : 1,
  localparam int unsigned LW     = clog2(SRC_DEPTH + 1)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic [LW-1:0]      iLEN,
  output logic               oRD_EN,
  output logic [SRC_AW-1:0]  oRD_ADDR,
  input  logic [DW-1:0]      iRD_DATA,
  output logic               oWR_EN,
  output logic [DST_AW-1:0]  oWR_ADDR,
  output logic [DW*PACK-1:0] oWR_DATA,
  output logic               oBUSY,
  output logic               oDONE
);

  rpc_state_t         state_q, state_d;
  logic [LW-1:0]      len_q, len_d, len_clamp;
  logic [SRC_AW-1:0]  rd_addr_q, rd_addr_d;
  logic [DST_AW-1:0]  wr_addr_q, wr_addr_d;
  logic [RD_LAT-1:0]  vld_q, last_q;
  logic               rd_en, rd_last, wr_en, wr_last;

  assign len_clamp = (iLEN > LW'(SRC_DEPTH)) ? LW'(SRC_DEPTH) : iLEN;
  assign rd_en     = (state_q == READ);
  assign rd_last   = rd_en && (LW'(rd_addr_q) == (len_q - LW'(1)));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_addr_d = rd_en ? rd_addr_q + SRC_AW'(1) : rd_addr_q;
    wr_addr_d = wr_en ? wr_addr_q + DST_AW'(1) : wr_addr_q;
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          len_d     = len_clamp;
          rd_addr_d = '0;
          wr_addr_d = '0;
          state_d   = (len_clamp == '0) ? DONE : READ;
        end
      end
      READ:    if (rd_last) state_d = DRAIN;
      DRAIN:   if (wr_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      vld_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      // Read strobe and last-read marker travel with the RAM latency so the
      // pipe output lines up with iRD_DATA.
      vld_q[0]  <= rd_en;
      last_q[0] <= rd_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  lane_packer #(
    .DW   (DW),
    .PACK (PACK)
  ) u_lane_packer (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iVALID   (vld_q[RD_LAT-1]),
    .iDATA    (iRD_DATA),
    .iFLUSH   (last_q[RD_LAT-1]),
    .oWR_EN   (wr_en),
    .oWR_DATA (oWR_DATA),
    .oWR_LAST (wr_last)
  );

  assign oRD_EN   = rd_en;
  assign oRD_ADDR = rd_addr_q;
  assign oWR_EN   = wr_en;
  assign oWR_ADDR = wr_addr_q;
  assign oBUSY    = (state_q != IDLE);
  assign oDONE    = (state_q == DONE);

endmodule

// File: tb/tb_read_pack_copy.sv
// Scoreboard bench for read_pack_copy: instance A uses the default
// parameters, instance B uses DW=16, PACK=2, SRC_DEPTH=8, RD_LAT=3.
module tb_read_pack_copy;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_start, a_rd_en, a_wr_en, a_busy, a_done;
  logic [5:0]   a_len, a_rd_addr;
  logic [27:0]  a_rd_data;
  logic [3:0]   a_wr_addr;
  logic [111:0] a_wr_data;

  logic         b_start, b_rd_en, b_wr_en, b_busy, b_done;
  logic [3:0]   b_len;
  logic [2:0]   b_rd_addr;
  logic [15:0]  b_rd_data;
  logic [1:0]   b_wr_addr;
  logic [31:0]  b_wr_data;

  read_pack_copy #(.DW(28), .PACK(4), .SRC_DEPTH(36), .RD_LAT(1)) u_dut_a (
    .iCLK(clk), .iRST(rst), .iSTART(a_start), .iLEN(a_len),
    .oRD_EN(a_rd_en), .oRD_ADDR(a_rd_addr), .iRD_DATA(a_rd_data),
    .oWR_EN(a_wr_en), .oWR_ADDR(a_wr_addr), .oWR_DATA(a_wr_data),
    .oBUSY(a_busy), .oDONE(a_done)
  );

  read_pack_copy #(.DW(16), .PACK(2), .SRC_DEPTH(8), .RD_LAT(3)) u_dut_b (
    .iCLK(clk), .iRST(rst), .iSTART(b_start), .iLEN(b_len),
    .oRD_EN(b_rd_en), .oRD_ADDR(b_rd_addr), .iRD_DATA(b_rd_data),
    .oWR_EN(b_wr_en), .oWR_ADDR(b_wr_addr), .oWR_DATA(b_wr_data),
    .oBUSY(b_busy), .oDONE(b_done)
  );

  // Source RAMs: word at address a holds a+1; junk when not read.
  always @(posedge clk) a_rd_data <= a_rd_en ? 28'(a_rd_addr) + 28'd1 : 28'hBADBAD0;
  logic [15:0] b_pipe [3];
  always @(posedge clk) begin
    b_pipe[0] <= b_rd_en ? 16'(b_rd_addr) + 16'd1 : 16'hDEAD;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_rd_data = b_pipe[2];

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int           addr;
    logic [111:0] data;
    int           cyc;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t wa, wb;
  int  ea = 0, eb = 0, rda_cnt = 0, rdb_cnt = 0;
  int  n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (a_rd_en) begin
      check("a_rd_addr", 112'(a_rd_addr), 112'(rda_cnt));
      check("a_rd_cycle", 112'(cyc - ea + 1), 112'(rda_cnt + 1));
      rda_cnt++;
    end
    if (a_wr_en) begin
      if (qa.size() == 0) check("a_wr_unexpected", 112'(qa.size()), 112'd1);
      else begin
        wa = qa.pop_front();
        check("a_wr_addr", 112'(a_wr_addr), 112'(wa.addr));
        check("a_wr_data", a_wr_data, wa.data);
        check("a_wr_cycle", 112'(cyc - ea + 1), 112'(wa.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (b_rd_en) begin
      check("b_rd_addr", 112'(b_rd_addr), 112'(rdb_cnt));
      rdb_cnt++;
    end
    if (b_wr_en) begin
      if (qb.size() == 0) check("b_wr_unexpected", 112'(qb.size()), 112'd1);
      else begin
        wb = qb.pop_front();
        check("b_wr_addr", 112'(b_wr_addr), 112'(wb.addr));
        check("b_wr_data", 112'(b_wr_data), wb.data);
        check("b_wr_cycle", 112'(cyc - eb + 1), 112'(wb.cyc));
      end
    end
  end

  // Job on instance A; optional extra iSTART pulses (p1, p2) and a reset
  // asserted in cycle rst_at (0 = none).
  task automatic run_a(input int len, input int p1, input int p2, input int rst_at);
    int clamp, nw, dexp, n, idx, nrd;
    wr_t w;
    logic [111:0] d;
    clamp = (len > 36) ? 36 : len;
    nw    = (clamp + 3) / 4;
    dexp  = (clamp == 0) ? 1 : clamp + 3;
    for (int j = 0; j < nw; j++) begin
      d = '0;
      for (int k = 0; k < 4; k++) begin
        idx = 4 * j + k;
        d = (d << 28) | ((idx < clamp) ? 112'(idx + 1) : 112'd0);
      end
      w.addr = j;
      w.data = d;
      w.cyc  = (4 * j + 6 < clamp + 2) ? 4 * j + 6 : clamp + 2;
      if (rst_at == 0 || w.cyc <= rst_at) qa.push_back(w);
    end
    rda_cnt = 0;
    @(negedge clk);
    a_len   = 6'(len);
    a_start = 1'b1;
    @(posedge clk);
    #1;
    ea      = cyc;
    a_start = 1'b0;
    for (int i = 0; i < dexp + 4; i++) begin
      @(negedge clk);
      n = cyc - ea + 1;
      if (rst_at > 0 && n > rst_at) begin
        check("a_rst_ctl", 112'({a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_busy, a_done}), 112'd0);
        check("a_rst_data", a_wr_data, 112'd0);
      end else begin
        check("a_busy", 112'(a_busy), 112'(n <= dexp));
        check("a_done", 112'(a_done), 112'(n == dexp));
      end
      rst     = (rst_at > 0 && n == rst_at);
      a_start = (n == p1 || n == p2);
    end
    rst     = 1'b0;
    a_start = 1'b0;
    nrd = (rst_at > 0 && rst_at < clamp) ? rst_at : clamp;
    check("a_writes_left", 112'(qa.size()), 112'd0);
    check("a_read_count", 112'(rda_cnt), 112'(nrd));
    qa.delete();
  endtask

  task automatic run_b(input int len);
    int clamp, nw, dexp, n, idx;
    wr_t w;
    logic [111:0] d;
    clamp = (len > 8) ? 8 : len;
    nw    = (clamp + 1) / 2;
    dexp  = (clamp == 0) ? 1 : clamp + 5;
    for (int j = 0; j < nw; j++) begin
      d = '0;
      for (int k = 0; k < 2; k++) begin
        idx = 2 * j + k;
        d = (d << 16) | ((idx < clamp) ? 112'(idx + 1) : 112'd0);
      end
      w.addr = j;
      w.data = d;
      w.cyc  = (2 * j + 6 < clamp + 4) ? 2 * j + 6 : clamp + 4;
      qb.push_back(w);
    end
    rdb_cnt = 0;
    @(negedge clk);
    b_len   = 4'(len);
    b_start = 1'b1;
    @(posedge clk);
    #1;
    eb      = cyc;
    b_start = 1'b0;
    for (int i = 0; i < dexp + 4; i++) begin
      @(negedge clk);
      n = cyc - eb + 1;
      check("b_busy", 112'(b_busy), 112'(n <= dexp));
      check("b_done", 112'(b_done), 112'(n == dexp));
    end
    check("b_writes_left", 112'(qb.size()), 112'd0);
    check("b_read_count", 112'(rdb_cnt), 112'(clamp));
    qb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    a_len   = '0;
    b_len   = '0;
    repeat (3) @(negedge clk);
    check("a_reset_ctl", 112'({a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_busy, a_done}), 112'd0);
    check("a_reset_data", a_wr_data, 112'd0);
    check("b_reset_ctl", 112'({b_rd_en, b_rd_addr, b_wr_en, b_wr_addr, b_busy, b_done}), 112'd0);
    check("b_reset_data", 112'(b_wr_data), 112'd0);
    rst = 1'b0;
    @(negedge clk);

    run_a(36, 0, 0, 0);
    run_a(10, 0, 0, 0);
    run_a(0, 0, 0, 0);
    run_a(63, 0, 0, 0);
    run_a(36, 5, 20, 0);
    run_a(36, 0, 0, 15);
    run_a(10, 0, 0, 0);
    run_a(1, 0, 0, 0);
    run_b(5);
    run_b(8);
    run_b(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_pack_copy.md
# read_pack_copy

Parametrised memory-to-memory packer. Reads `iLEN` narrow words from a source RAM (mem0), concatenates every `PACK` consecutive words into one wide word, and writes the wide words to consecutive addresses of a destination RAM (mem1). It sits between the feature buffer and the wide-word stage buffer of the STFT/CNN datapath. It adds three things the fixed 28-bit/4-word copier lacks: configurable read latency, runtime length with zero-padded tail flush, and an explicit write strobe plus done handshake.

## Interface
- `DW`, 28: source word width.
- `PACK`, 4: source words per destination word (≥1).
- `SRC_DEPTH`, 36: maximum words read per job.
- `RD_LAT`, 1: source RAM read latency in cycles (≥1).
- Derived: `SRC_AW = clog2(SRC_DEPTH)`, `DST_AW = clog2(ceil(SRC_DEPTH/PACK))`, `LW = clog2(SRC_DEPTH+1)`.

Ports:
- `iCLK`, in, 1: clock, rising edge.
- `iRST`, in, 1: synchronous, active-high reset.
- `iSTART`, in, 1: job request; sampled only in IDLE.
- `iLEN`, in, LW: number of source words; values above SRC_DEPTH clamp to SRC_DEPTH.
- `oRD_EN`, out, 1: source read strobe.
- `oRD_ADDR`, out, SRC_AW: source address.
- `iRD_DATA`, in, DW: source data, valid RD_LAT cycles after the corresponding `oRD_EN`.
- `oWR_EN`, out, 1: destination write strobe.
- `oWR_ADDR`, out, DST_AW: destination address.
- `oWR_DATA`, out, DW*PACK: packed word.
- `oBUSY`, out, 1: high from the cycle after accept until `oDONE`, inclusive.
- `oDONE`, out, 1: one-cycle job-complete pulse.

## Operation
- FSM states:
  - IDLE: go to READ on `iSTART`; go directly to DONE if the clamped length is 0.
  - READ: issues `len` reads. Go to DRAIN after the last read.
  - DRAIN: wait until all in-flight data is captured and the final write has issued.
  - DONE: one cycle, then IDLE.
- Reads: `oRD_EN=1` for exactly `len` consecutive cycles; `oRD_ADDR` runs 0,1,…,len-1.
- Valid tracking: an RD_LAT-deep shift register of `oRD_EN` marks the capture cycles.
- Packing:
  - The first word of each group occupies the MSB lane `[DW*PACK-1 -: DW]`; later words fill downward.
  - A lane counter (0…PACK-1) wraps after PACK captures.
  - The pack register clears after each write.
- Write: registered. `oWR_EN` is high the cycle after the PACK-th word of a group is captured. `oWR_ADDR` starts at 0 and increments after each write.
- Tail: if `len % PACK ≠ 0`, the partial group is written the cycle after the final capture. Unfilled lower lanes are zero.
- Writes per job = `ceil(len/PACK)`.
- `iSTART` outside IDLE is ignored; no queuing.
- Reset: all outputs 0, `oRD_ADDR`/`oWR_ADDR`/`oWR_DATA` = 0, state IDLE, lane counter and pack register cleared.
- Reset mid-job aborts immediately: no further reads or writes, no `oDONE`.

## Timing
- Cycle 0 is the edge at which `iSTART` is sampled in IDLE.
- Read `a` is issued in cycle 1+a; its data is captured at the end of cycle 1+a+RD_LAT.
- Full group j is written in cycle `1+PACK*(j+1)+RD_LAT`.
- Tail group is written in cycle `1+len+RD_LAT`.
- `oDONE` falls in the cycle after the final write; IDLE follows. A new `iSTART` is accepted in the cycle after `oDONE`.
- `len=0`: `oDONE` in cycle 1, no reads or writes, `oBUSY` high in cycle 1 only.
- Sustained throughput: one source word per cycle, one write per PACK cycles. Same-cycle capture and write is handled by the registered write path.

## Structure
- Shared package `stft_pkg`:
  - `clog2` function.
  - FSM state enum `rpc_state_t` (IDLE, READ, DRAIN, DONE).
- One sub-module, `lane_packer`: lane counter, pack register, and registered write strobe/data. Parameters DW, PACK; inputs capture-valid, data, flush.
- The top level holds the FSM, read address counter, RD_LAT valid pipe, and write address counter.

## Test plan
- Defaults, `iLEN=36`, source word a = a+1:
  - 36 reads, addr 0..35.
  - 9 writes to addr 0..8 in cycles 6,10,…,38.
  - Write 0 = {28'd1,28'd2,28'd3,28'd4}.
  - `oDONE` in cycle 39.
- Defaults, `iLEN=10`: 3 writes. Write 2 = {28'd9,28'd10,56'd0} in cycle 12; `oDONE` in cycle 13.
- `iLEN=0`: no `oRD_EN`/`oWR_EN`; `oDONE` in cycle 1. `iLEN=63`: clamps to 36, same response as the first scenario.
- `RD_LAT=3`, `PACK=2`, `DW=16`, `iLEN=5`: writes in cycles 6, 8, 9. Last write = {16'd5,16'd0}.
- `iSTART` pulsed in cycles 5 and 20 of a 36-word job: ignored; exactly 9 writes and one `oDONE`.
- `iRST` asserted in cycle 15 of a 36-word job:
  - All outputs 0 from cycle 16.
  - No `oDONE`.
  - A new job started afterward writes from addr 0 with correct first-word packing.
